// File: rtl/clk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_ctrl_pkg
// Description : Shared state encoding and default timing constants for the
//               DCM reset/lock sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam int c_rst_hold_cycles = 8;
    localparam int c_lock_timeout    = 65536;
    localparam int c_max_retries     = 3;
    localparam int c_release_delay   = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcm_lock_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dcm_lock_ctrl_if
// Description : DCM control/status bundle between the lock sequencer (slave)
//               and the DCM / downstream reset consumers (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface dcm_lock_ctrl_if
    import clk_ctrl_pkg::*;
#(
    parameter int MAX_RETRIES = c_max_retries
) ();

    localparam int c_rw = $clog2(MAX_RETRIES + 1);

    logic            restart;
    logic            dcm_locked;
    logic [7:0]      dcm_status;
    logic            dcm_rst;
    logic            clk_en;
    logic            sys_rst_n;
    logic            fail;
    logic [c_rw-1:0] retry_cnt;

    modport master (
        output restart, dcm_locked, dcm_status,
        input  dcm_rst, clk_en, sys_rst_n, fail, retry_cnt
    );

    modport slave (
        input  restart, dcm_locked, dcm_status,
        output dcm_rst, clk_en, sys_rst_n, fail, retry_cnt
    );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer with asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/dcm_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcm_lock_ctrl
// Description : DCM_SP reset/lock sequencer: holds DCM reset, waits for lock
//               with timeout and bounded retries, gates the BUFGCE enable and
//               releases the downstream system reset after a settle delay.
//               Optional macro DCM_LOCK_CTRL_STATUS_EN: treat DCM STATUS[1]
//               (CLKFX stopped) as loss of lock.
// Revision    : 1.0 - initial release
// ============================================================================
module dcm_lock_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = c_rst_hold_cycles,
    parameter int LOCK_TIMEOUT    = c_lock_timeout,
    parameter int MAX_RETRIES     = c_max_retries,
    parameter int RELEASE_DELAY   = c_release_delay
) (
    input  wire logic     fpga_clk,
    input  wire logic     reset_n,
    dcm_lock_ctrl_if.slave bus
);

    localparam int c_cnt_max = max3(RST_HOLD_CYCLES, LOCK_TIMEOUT, RELEASE_DELAY);
    localparam int c_cw      = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam int c_rw      = $clog2(MAX_RETRIES + 1);

    state_t            r_state;
    logic [c_cw-1:0]   r_cnt;
    logic [c_rw-1:0]   r_retry;
    logic              r_dcm_rst;
    logic              r_clk_en;
    logic              r_sys_rst_n;
    logic              r_fail;

    logic              w_locked_s;
    logic              w_stopped_s;
    logic              w_unused_status;
    logic              w_loss;
    logic              w_hold_done;
    logic              w_timeout;
    logic              w_release;
    logic              w_retry_exhausted;
    state_t            w_retry_state;
    logic [c_rw-1:0]   w_retry_next;

    sync_2ff #(.WIDTH(1)) u_sync_locked (
        .i_clk   (fpga_clk),
        .i_rst_n (reset_n),
        .i_d     (bus.dcm_locked),
        .o_q     (w_locked_s)
    );

`ifdef DCM_LOCK_CTRL_STATUS_EN
    sync_2ff #(.WIDTH(1)) u_sync_stopped (
        .i_clk   (fpga_clk),
        .i_rst_n (reset_n),
        .i_d     (bus.dcm_status[1]),
        .o_q     (w_stopped_s)
    );
    assign w_unused_status = ^{bus.dcm_status[7:2], bus.dcm_status[0]};
`else
    assign w_stopped_s     = 1'b0;
    assign w_unused_status = ^bus.dcm_status;
`endif

    assign w_loss            = !w_locked_s || w_stopped_s;
    assign w_hold_done       = (r_cnt == c_cw'(RST_HOLD_CYCLES - 1));
    assign w_timeout         = (r_cnt == c_cw'(LOCK_TIMEOUT - 1));
    assign w_release         = (r_cnt == c_cw'(RELEASE_DELAY - 1));

    // A failed attempt either retries from HOLD or, once the budget is spent,
    // parks in FAIL with the counter saturated.
    assign w_retry_exhausted = (r_retry == c_rw'(MAX_RETRIES));
    assign w_retry_state     = w_retry_exhausted ? ST_FAIL : ST_HOLD;
    assign w_retry_next      = w_retry_exhausted ? r_retry : (r_retry + c_rw'(1));

    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_dcm_rst   <= 1'b1;
            r_clk_en    <= 1'b0;
            r_sys_rst_n <= 1'b0;
            r_fail      <= 1'b0;
        end else if (bus.restart) begin
            // Outputs jump straight to HOLD values so the DCM sees reset at once.
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_dcm_rst   <= 1'b1;
            r_clk_en    <= 1'b0;
            r_sys_rst_n <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_dcm_rst   <= (r_state == ST_HOLD) || (r_state == ST_FAIL);
            r_clk_en    <= (r_state == ST_SETTLE) || (r_state == ST_RUN);
            r_sys_rst_n <= (r_state == ST_RUN);
            r_fail      <= (r_state == ST_FAIL);

            case (r_state)
                ST_HOLD: begin
                    if (w_hold_done) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + c_cw'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_stopped_s) begin
                        r_state <= w_retry_state;
                        r_retry <= w_retry_next;
                        r_cnt   <= '0;
                    end else if (w_locked_s) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= w_retry_state;
                        r_retry <= w_retry_next;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + c_cw'(1);
                    end
                end
                ST_SETTLE: begin
                    if (w_loss) begin
                        r_state <= w_retry_state;
                        r_retry <= w_retry_next;
                        r_cnt   <= '0;
                    end else if (w_release) begin
                        r_state <= ST_RUN;
                        r_retry <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + c_cw'(1);
                    end
                end
                ST_RUN: begin
                    if (w_loss) begin
                        r_state <= w_retry_state;
                        r_retry <= w_retry_next;
                        r_cnt   <= '0;
                    end
                end
                ST_FAIL: begin
                    r_state <= ST_FAIL;
                end
                default: begin
                    r_state <= ST_HOLD;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.dcm_rst   = r_dcm_rst;
    assign bus.clk_en    = r_clk_en;
    assign bus.sys_rst_n = r_sys_rst_n;
    assign bus.fail      = r_fail;
    assign bus.retry_cnt = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_dcm_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcm_lock_ctrl
// Description : Self-checking bench for dcm_lock_ctrl (H=8, T=64, M=2, R=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcm_lock_ctrl;

    localparam int c_hold  = 8;
    localparam int c_tmo   = 64;
    localparam int c_retry = 2;
    localparam int c_rel   = 16;
`ifdef DCM_LOCK_CTRL_STATUS_EN
    localparam bit c_status_en = 1'b1;
`else
    localparam bit c_status_en = 1'b0;
`endif

    typedef struct {
        string      name;
        logic       rst_n;
        logic       locked;
        logic       restart;
        int         cycles;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        int         at;
        logic [5:0] v;
    } exp_t;

    logic fpga_clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   failures;
    event chk_now;
    exp_t sb[$];
    vec_t vecs[$];

    dcm_lock_ctrl_if #(.MAX_RETRIES(c_retry)) bus ();

    dcm_lock_ctrl #(
        .RST_HOLD_CYCLES (c_hold),
        .LOCK_TIMEOUT    (c_tmo),
        .MAX_RETRIES     (c_retry),
        .RELEASE_DELAY   (c_rel)
    ) u_dut (
        .fpga_clk (fpga_clk),
        .reset_n  (reset_n),
        .bus      (bus.slave)
    );

    initial fpga_clk = 1'b0;
    always #5 fpga_clk = ~fpga_clk;

    initial cyc = 0;
    always @(posedge fpga_clk) cyc <= cyc + 1;

    // {dcm_rst, clk_en, sys_rst_n, fail, retry_cnt}
    function automatic logic [5:0] mk(input bit d, input bit c, input bit s, input bit f, input int r);
        logic [1:0] rr;
        rr = 2'(r);
        return {d, c, s, f, rr};
    endfunction

    function automatic logic [5:0] obs();
        return {bus.dcm_rst, bus.clk_en, bus.sys_rst_n, bus.fail, bus.retry_cnt};
    endfunction

    task automatic expect_in(input string nm, input int delta, input logic [5:0] v);
        exp_t e;
        e.name = nm;
        e.at   = cyc + delta;
        e.v    = v;
        sb.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge fpga_clk);
        #2;
    endtask

    function automatic void add(input string nm, input logic rn, input logic lk,
                                input logic rs, input int n, input logic [5:0] v);
        vec_t x;
        x.name = nm; x.rst_n = rn; x.locked = lk; x.restart = rs; x.cycles = n; x.exp = v;
        vecs.push_back(x);
    endfunction

    // Single comparison point: pops due expectations at each falling edge or on demand.
    always @(negedge fpga_clk or chk_now) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            checks = checks + 1;
            if (e.at < cyc) begin
                failures = failures + 1;
                $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", e.name, e.at, cyc);
            end else if (obs() !== e.v) begin
                failures = failures + 1;
                $display("FAIL %s @cyc %0d: got {rst,ce,srn,fail,retry}=%b required %b",
                         e.name, cyc, obs(), e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        bus.restart = 1'b0;
        bus.dcm_locked = 1'b0;
        bus.dcm_status = 8'h00;

        add("reset",          1'b0, 1'b0, 1'b0,  3, mk(1,0,0,0,0));
        add("hold_last",      1'b1, 1'b0, 1'b0,  8, mk(1,0,0,0,0));
        add("hold_done",      1'b1, 1'b0, 1'b0,  1, mk(0,0,0,0,0));
        add("wait_lock",      1'b1, 1'b0, 1'b0, 11, mk(0,0,0,0,0));
        add("lock_pre",       1'b1, 1'b1, 1'b0,  3, mk(0,0,0,0,0));
        add("lock_settle",    1'b1, 1'b1, 1'b0,  1, mk(0,1,0,0,0));
        add("settle_last",    1'b1, 1'b1, 1'b0, 15, mk(0,1,0,0,0));
        add("run",            1'b1, 1'b1, 1'b0,  1, mk(0,1,1,0,0));
        add("drop",           1'b1, 1'b0, 1'b0,  1, mk(0,1,1,0,0));
        add("drop_end",       1'b1, 1'b1, 1'b0,  1, mk(0,1,1,0,0));
        add("loss_retry",     1'b1, 1'b1, 1'b0,  1, mk(0,1,1,0,1));
        add("loss_out",       1'b1, 1'b1, 1'b0,  1, mk(1,0,0,0,1));
        add("relock_hold",    1'b1, 1'b1, 1'b0,  7, mk(1,0,0,0,1));
        add("relock_wait",    1'b1, 1'b1, 1'b0,  1, mk(0,0,0,0,1));
        add("relock_settle",  1'b1, 1'b1, 1'b0,  1, mk(0,1,0,0,1));
        add("relock_clear",   1'b1, 1'b1, 1'b0, 15, mk(0,1,0,0,0));
        add("relock_run",     1'b1, 1'b1, 1'b0,  1, mk(0,1,1,0,0));
        add("lost_retry",     1'b1, 1'b0, 1'b0,  3, mk(0,1,1,0,1));
        add("lost_out",       1'b1, 1'b0, 1'b0,  1, mk(1,0,0,0,1));
        add("retry1_wait",    1'b1, 1'b0, 1'b0,  8, mk(0,0,0,0,1));
        add("retry1_pre_tmo", 1'b1, 1'b0, 1'b0, 62, mk(0,0,0,0,1));
        add("timeout1",       1'b1, 1'b0, 1'b0,  1, mk(0,0,0,0,2));
        add("retry2_hold",    1'b1, 1'b0, 1'b0,  1, mk(1,0,0,0,2));
        add("retry2_wait",    1'b1, 1'b0, 1'b0,  8, mk(0,0,0,0,2));
        add("retry2_pre_tmo", 1'b1, 1'b0, 1'b0, 63, mk(0,0,0,0,2));
        add("fail",           1'b1, 1'b0, 1'b0,  1, mk(1,0,0,1,2));
        add("fail_sticky",    1'b1, 1'b0, 1'b0, 50, mk(1,0,0,1,2));
        add("fail_absorb",    1'b1, 1'b1, 1'b0, 10, mk(1,0,0,1,2));
        add("restart",        1'b1, 1'b1, 1'b1,  1, mk(1,0,0,0,0));
        add("restart_hold",   1'b1, 1'b1, 1'b0,  8, mk(1,0,0,0,0));
        add("restart_wait",   1'b1, 1'b1, 1'b0,  1, mk(0,0,0,0,0));
        add("restart_settle", 1'b1, 1'b1, 1'b0,  1, mk(0,1,0,0,0));
        add("restart_run",    1'b1, 1'b1, 1'b0, 16, mk(0,1,1,0,0));

        run(1);
        foreach (vecs[i]) begin
            reset_n        = vecs[i].rst_n;
            bus.dcm_locked = vecs[i].locked;
            bus.restart    = vecs[i].restart;
            expect_in(vecs[i].name, vecs[i].cycles, vecs[i].exp);
            run(vecs[i].cycles);
        end

        // STATUS[1] pulse while running: loss only when the status path is built.
        bus.dcm_status = 8'h02;
        expect_in("stat_pre", 1, mk(0,1,1,0,0));
        run(1);
        bus.dcm_status = 8'h00;
        expect_in("stat_retry", 2, c_status_en ? mk(0,1,1,0,1) : mk(0,1,1,0,0));
        expect_in("stat_out",   3, c_status_en ? mk(1,0,0,0,1) : mk(0,1,1,0,0));
        expect_in("stat_run",  28, mk(0,1,1,0,0));
        run(28);

        // Async reset in SETTLE, then lock arriving exactly on the timeout edge.
        bus.restart = 1'b1;
        expect_in("settle_reach", 13, mk(0,1,0,0,0));
        run(1);
        bus.restart = 1'b0;
        run(12);
        reset_n = 1'b0;
        bus.dcm_locked = 1'b0;
        #1;
        expect_in("async_reset", 0, mk(1,0,0,0,0));
        -> chk_now;
        #1;
        run(2);
        reset_n = 1'b1;
        expect_in("rel_hold_last", 8, mk(1,0,0,0,0));
        expect_in("rel_hold_done", 9, mk(0,0,0,0,0));
        run(69);
        bus.dcm_locked = 1'b1;
        expect_in("lock_tmo_pre", 3, mk(0,0,0,0,0));
        expect_in("lock_beats_tmo", 4, mk(0,1,0,0,0));
        run(6);

        -> chk_now;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
